// File: rtl/ram64_loader.sv
// Streams COUNT words into a RAM64 over valid/ready, then reads the region back and
// compares a 16-bit read checksum against the write checksum.
module ram64_loader #(
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned COUNT      = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] ram_in,
    output logic [5:0]  ram_addr,
    output logic        ram_load,
    input  logic [15:0] ram_out,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] checksum
);

    typedef enum logic [1:0] {StIdle, StWrite, StVerify, StDone} state_e;

    localparam logic [5:0] StartPtr = 6'(START_ADDR);
    localparam logic [6:0] LastIdx  = 7'(COUNT - 1);

    state_e      state_q, state_d;
    logic [5:0]  ptr_q, ptr_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [15:0] wsum_q, wsum_d;
    logic [15:0] rsum_q, rsum_d;
    logic [15:0] checksum_q, checksum_d;
    logic        error_q, error_d;
    logic [15:0] rsum_next;
    logic        last;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            cnt_q      <= '0;
            wsum_q     <= '0;
            rsum_q     <= '0;
            checksum_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            wsum_q     <= wsum_d;
            rsum_q     <= rsum_d;
            checksum_q <= checksum_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        wsum_d     = wsum_q;
        rsum_d     = rsum_q;
        checksum_d = checksum_q;
        error_d    = error_q;
        rsum_next  = rsum_q + ram_out;
        last       = (cnt_q == LastIdx);
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWrite;
                    ptr_d   = StartPtr;
                    cnt_d   = '0;
                    wsum_d  = '0;
                    rsum_d  = '0;
                    error_d = 1'b0;
                end
            end
            StWrite: begin
                if (s_valid) begin
                    wsum_d = wsum_q + s_data;
                    ptr_d  = ptr_q + 6'd1;
                    cnt_d  = cnt_q + 7'd1;
                    if (last) begin
                        state_d = StVerify;
                        ptr_d   = StartPtr;
                        cnt_d   = '0;
                    end
                end
            end
            StVerify: begin
                rsum_d = rsum_next;
                ptr_d  = ptr_q + 6'd1;
                cnt_d  = cnt_q + 7'd1;
                if (last) begin
                    error_d    = (rsum_next != wsum_q);
                    checksum_d = wsum_q;
                    state_d    = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Write strobe is gated by reset so a synchronous reset can never coincide with a RAM write.
    always_comb begin
        s_ready  = reset_n && (state_q == StWrite);
        ram_load = s_ready && s_valid;
        ram_in   = (state_q == StWrite) ? s_data : 16'h0000;
        ram_addr = (state_q == StWrite || state_q == StVerify) ? ptr_q : StartPtr;
        busy     = (state_q == StWrite || state_q == StVerify);
        done     = (state_q == StDone);
        error    = error_q;
        checksum = checksum_q;
    end

endmodule
